magnetron_sr_driver: RTL and testbench
======================================

Name: magnetron_sr_driver

Overview:
- Sequential front end that generates the Set/Reset inputs for the magnetron SR latch in the Control_Magnetron datapath.
- Turns raw start/stop buttons, the door sensor and the cook-timer expiry into clean, mutually exclusive, single-cycle S and R pulses.
- Enforces a restart hold-off and reports why the magnetron was last switched off.

Parameters:
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized cycles needed before a button level is accepted (min 1).
- HOLDOFF_CYCLES, 8, cycles after any switch-off during which start is ignored (min 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start_btn  in  1  raw start button, async, 1 = pressed.
- stop_btn  in  1  raw stop/cancel button, async, 1 = pressed.
- door_closed  in  1  raw door sensor, async, 1 = closed.
- timer_done  in  1  cook timer expired, async level.
- S  out  1  latch set pulse.
- R  out  1  latch reset pulse.
- mag_on  out  1  driver's view of latch state.
- off_cause  out  2  last switch-off cause: 0 none/reset, 1 door, 2 stop, 3 timer.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low; ports named clk and rst_n.
- Reset asserted: S=0, R=1 (forces latch off), mag_on=0, off_cause=0, state=HOLDOFF, holdoff counter=HOLDOFF_CYCLES-1, debounced levels=0, synchronizers=0.
- Synchronization: every input passes through a 2-FF synchronizer. A raw change sampled at edge 0 appears in the synchronized signal at edge 2.
- Debounce (start, stop only):
  - Counter increments while the synced value differs from the debounced level.
  - Counter clears when they are equal.
  - Debounced level flips on the edge where the count would reach DEBOUNCE_CYCLES, i.e. edge 2+DEBOUNCE_CYCLES.
- Events: start_evt and stop_evt are rising edges of the debounced levels (one cycle). door_closed and timer_done use synced levels directly, with no debounce.
- FSM states: IDLE, ON, HOLDOFF. S and R are registered, asserted only on the edge that takes a transition, for exactly one cycle.
  - IDLE -> ON when start_evt & door_sync & ~timer_sync & ~stop_evt: S=1, mag_on=1, off_cause unchanged.
  - IDLE, start with door open, timer_sync=1, or simultaneous stop_evt: stay IDLE, no pulse; the start event is discarded.
  - ON -> HOLDOFF when ~door_sync | stop_evt | timer_sync: R=1, mag_on=0, counter=HOLDOFF_CYCLES-1.
  - ON off_cause priority: door(1) > stop(2) > timer(3).
  - HOLDOFF: counter decrements each cycle; at 0 -> IDLE with no pulse. start_evt is ignored, not queued.
- S=1 and R=1 in the same cycle is illegal and must never occur. S=0,R=0 is the hold state.
- Latency:
  - Raw start rise (edge 0) to S high: edge 3+DEBOUNCE_CYCLES (edge 7 at default).
  - Raw door open to R high: edge 3.
  - Raw timer_done rise to R high: edge 3.
- After reset release: R stays 1 until the first edge, then 0. HOLDOFF then runs its full HOLDOFF_CYCLES before IDLE.
- Reset mid-ON: R forced 1 asynchronously and mag_on=0 immediately. Behaviour after release is as for power-up.
- A button held continuously produces one event only. A new event requires release, debounced low, then press.

Decomposition:
- Package magnetron_pkg:
  - state encoding constants ST_IDLE, ST_ON, ST_HOLDOFF.
  - cause codes CAUSE_NONE, CAUSE_DOOR, CAUSE_STOP, CAUSE_TIMER (2-bit).
- Sub-module btn_debounce (2-FF sync + debounce counter, parameter DEBOUNCE_CYCLES, outputs level and rise pulse), instantiated for start and stop.
- door_closed and timer_done use plain 2-FF synchronizers inline.

Test Plan:
- Reset then idle 9 cycles, door_closed=1, start_btn held from edge 0 -> S=1 for exactly one cycle at edge 7; mag_on=1; R=0 throughout.
- While ON, door_closed -> 0 at edge 0 -> R=1 one cycle at edge 3; off_cause=1; mag_on=0. A start press within 8 cycles produces no S.
- Start glitch of 3 cycles (less than DEBOUNCE_CYCLES) -> no S. Stable 4-cycle press -> S at edge 7.
- In ON, stop_btn and timer_done rise on the same edge -> R pulse at edge 3 from timer (off_cause=3). Stop arrives debounced 4 cycles later and causes no second R.
- Start and stop debounced on the same cycle in IDLE -> no S, stays IDLE. Start with timer_done=1 -> no S.
- rst_n dropped mid-ON -> R=1 and mag_on=0 without a clock edge. After release, HOLDOFF lasts 8 cycles before start is accepted. Assert S&R never both 1 across all tests.

Source files
------------

// File: rtl/magnetron_pkg.sv
// Shared FSM state encoding and switch-off cause codes for the magnetron SR driver.
package magnetron_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ON      = 2'd1,
        ST_HOLDOFF = 2'd2
    } state_t;

    localparam logic [1:0] CAUSE_NONE  = 2'd0;
    localparam logic [1:0] CAUSE_DOOR  = 2'd1;
    localparam logic [1:0] CAUSE_STOP  = 2'd2;
    localparam logic [1:0] CAUSE_TIMER = 2'd3;

    // Door opening outranks a stop press, which outranks timer expiry.
    function automatic logic [1:0] off_cause_of(input logic door_open,
                                                 input logic stop,
                                                 input logic timer);
        logic [1:0] cause;
        cause = CAUSE_NONE;
        if (door_open)  cause = CAUSE_DOOR;
        else if (stop)  cause = CAUSE_STOP;
        else if (timer) cause = CAUSE_TIMER;
        return cause;
    endfunction

endpackage

// File: rtl/magnetron_sr_driver_btn_debounce.sv
// Purpose: 2-FF synchronizer plus stability counter for one raw push button.
// Latency: level and rise change DEBOUNCE_CYCLES+2 edges after a raw change.
// Backpressure: none; free-running level sampler.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic level,
    output logic rise
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          meta;
    logic          sync;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta  <= 1'b0;
            sync  <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            meta <= btn;
            sync <= meta;
            rise <= 1'b0;
            // The level flips on the edge where the run of disagreement would reach the limit.
            if (sync != level) begin
                if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    level <= sync;
                    cnt   <= '0;
                    rise  <= sync;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/magnetron_sr_driver.sv
// Purpose: turn start/stop/door/timer inputs into exclusive one-cycle S/R latch pulses.
// Latency: raw start to S = DEBOUNCE_CYCLES+3 edges; door open or timer to R = 3 edges.
// Backpressure: none; start events outside IDLE are dropped, never queued.
module magnetron_sr_driver
    import magnetron_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int HOLDOFF_CYCLES  = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start_btn,
    input  logic       stop_btn,
    input  logic       door_closed,
    input  logic       timer_done,
    output logic       S,
    output logic       R,
    output logic       mag_on,
    output logic [1:0] off_cause
);
    localparam int HW = $clog2(HOLDOFF_CYCLES + 1);

    logic          start_lvl, start_evt;
    logic          stop_lvl, stop_evt;
    logic          door_meta, door_sync;
    logic          timer_meta, timer_sync;
    logic          unused_lvl;
    state_t        state;
    logic [HW-1:0] hold_cnt;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start_db (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (start_btn),
        .level (start_lvl),
        .rise  (start_evt)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_stop_db (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (stop_btn),
        .level (stop_lvl),
        .rise  (stop_evt)
    );

    // Debounced levels are kept for observability only; the FSM acts on edges.
    assign unused_lvl = start_lvl ^ stop_lvl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            door_meta  <= 1'b0;
            door_sync  <= 1'b0;
            timer_meta <= 1'b0;
            timer_sync <= 1'b0;
        end else begin
            door_meta  <= door_closed;
            door_sync  <= door_meta;
            timer_meta <= timer_done;
            timer_sync <= timer_meta;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_HOLDOFF;
            hold_cnt  <= HW'(HOLDOFF_CYCLES - 1);
            S         <= 1'b0;
            R         <= 1'b1;
            mag_on    <= 1'b0;
            off_cause <= CAUSE_NONE;
        end else begin
            S <= 1'b0;
            R <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start_evt && door_sync && !timer_sync && !stop_evt) begin
                        state  <= ST_ON;
                        S      <= 1'b1;
                        mag_on <= 1'b1;
                    end
                end
                ST_ON: begin
                    if (!door_sync || stop_evt || timer_sync) begin
                        state     <= ST_HOLDOFF;
                        R         <= 1'b1;
                        mag_on    <= 1'b0;
                        off_cause <= off_cause_of(!door_sync, stop_evt, timer_sync);
                        hold_cnt  <= HW'(HOLDOFF_CYCLES - 1);
                    end
                end
                ST_HOLDOFF: begin
                    if (hold_cnt == '0) begin
                        state <= ST_IDLE;
                    end else begin
                        hold_cnt <= hold_cnt - HW'(1);
                    end
                end
                default: begin
                    state <= ST_HOLDOFF;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_magnetron_sr_driver.sv
// Directed plus randomized bench for magnetron_sr_driver against an edge-indexed reference model.
module tb_magnetron_sr_driver;
    localparam int DB = 4;
    localparam int HO = 8;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       start_btn = 1'b0;
    logic       stop_btn = 1'b0;
    logic       door_closed = 1'b0;
    logic       timer_done = 1'b0;
    logic       S, R, mag_on;
    logic [1:0] off_cause;

    int tests = 0;
    int fails = 0;
    int s_cnt = 0;
    int r_cnt = 0;

    // Reference model state: mode 0 idle, 1 on, 2 holdoff; hold expires at an absolute edge.
    int       m_edge, m_mode, hold_until;
    bit       e_S, e_R, e_on;
    bit [1:0] e_cause;
    bit       d_1, d_s, t_1, t_s;
    bit       st_1, st_s, st_lvl, st_evt;
    bit       sp_1, sp_s, sp_lvl, sp_evt;
    int       st_run, sp_run;

    always #5 clk = ~clk;

    magnetron_sr_driver #(.DEBOUNCE_CYCLES(DB), .HOLDOFF_CYCLES(HO)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start_btn   (start_btn),
        .stop_btn    (stop_btn),
        .door_closed (door_closed),
        .timer_done  (timer_done),
        .S           (S),
        .R           (R),
        .mag_on      (mag_on),
        .off_cause   (off_cause)
    );

    task automatic check(input string tag, input logic [1:0] obs, input logic [1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_edge = 0; m_mode = 2; hold_until = HO;
        e_S = 0; e_R = 1; e_on = 0; e_cause = 0;
        d_1 = 0; d_s = 0; t_1 = 0; t_s = 0;
        st_1 = 0; st_s = 0; st_lvl = 0; st_evt = 0; st_run = 0;
        sp_1 = 0; sp_s = 0; sp_lvl = 0; sp_evt = 0; sp_run = 0;
    endtask

    // A button level is accepted once the synced value has disagreed for DB edges in a row.
    task automatic deb(input bit sync, inout bit lvl, inout bit evt, inout int run);
        evt = 0;
        if (sync != lvl) begin
            run++;
            if (run == DB) begin
                lvl = sync;
                run = 0;
                evt = sync;
            end
        end else begin
            run = 0;
        end
    endtask

    task automatic model_edge(input bit st, input bit sp, input bit dr, input bit tm);
        m_edge++;
        e_S = 0;
        e_R = 0;
        case (m_mode)
            0: if (st_evt && d_s && !t_s && !sp_evt) begin
                   e_S = 1; e_on = 1; m_mode = 1;
               end
            1: if (!d_s || sp_evt || t_s) begin
                   e_R = 1; e_on = 0; m_mode = 2;
                   e_cause = !d_s ? 2'd1 : (sp_evt ? 2'd2 : 2'd3);
                   hold_until = m_edge + HO;
               end
            default: if (m_edge >= hold_until) m_mode = 0;
        endcase
        deb(st_s, st_lvl, st_evt, st_run);
        deb(sp_s, sp_lvl, sp_evt, sp_run);
        d_s = d_1;   d_1 = dr;
        t_s = t_1;   t_1 = tm;
        st_s = st_1; st_1 = st;
        sp_s = sp_1; sp_1 = sp;
    endtask

    task automatic tick(input int n);
        bit st, sp, dr, tm;
        for (int i = 0; i < n; i++) begin
            st = start_btn; sp = stop_btn; dr = door_closed; tm = timer_done;
            @(posedge clk);
            #1;
            model_edge(st, sp, dr, tm);
            check("S", S, e_S);
            check("R", R, e_R);
            check("mag_on", mag_on, e_on);
            check("off_cause", off_cause, e_cause);
            check("s_r_exclusive", S & R, 1'b0);
            s_cnt += int'(S);
            r_cnt += int'(R);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_S", S, 1'b0);
        check("rst_R", R, 1'b1);
        check("rst_mag_on", mag_on, 1'b0);
        check("rst_cause", off_cause, 2'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #2;
        do_reset();

        // Power-up holdoff, then a held start press fires S seven edges later.
        door_closed = 1'b1;
        tick(9);
        s_cnt = 0; r_cnt = 0;
        start_btn = 1'b1;
        tick(7);
        check("start_s_edge7", S, 1'b1);
        tick(3);
        check("start_one_s", 2'(s_cnt), 2'd1);
        check("start_no_r", 2'(r_cnt), 2'd0);
        check("start_on", mag_on, 1'b1);
        start_btn = 1'b0;
        tick(8);

        // Door opens while on; a start press inside holdoff is dropped.
        door_closed = 1'b0;
        tick(3);
        check("door_r_edge3", R, 1'b1);
        check("door_cause", off_cause, 2'd1);
        tick(1);
        door_closed = 1'b1;
        start_btn = 1'b1;
        s_cnt = 0;
        tick(15);
        check("holdoff_no_s", 2'(s_cnt), 2'd0);
        start_btn = 1'b0;
        tick(8);

        // Short glitch is rejected; a stable press is accepted.
        start_btn = 1'b1;
        tick(3);
        start_btn = 1'b0;
        tick(10);
        check("glitch_no_s", 2'(s_cnt), 2'd0);
        start_btn = 1'b1;
        tick(7);
        check("stable_s_edge7", S, 1'b1);
        tick(1);
        start_btn = 1'b0;
        tick(8);

        // Stop and timer together: timer wins, late stop adds no second R.
        r_cnt = 0;
        stop_btn = 1'b1;
        timer_done = 1'b1;
        tick(3);
        check("timer_r_edge3", R, 1'b1);
        check("timer_cause", off_cause, 2'd3);
        tick(10);
        check("timer_one_r", 2'(r_cnt), 2'd1);
        stop_btn = 1'b0;
        timer_done = 1'b0;
        tick(20);

        // Start with simultaneous stop, then start with timer asserted: both ignored.
        s_cnt = 0;
        start_btn = 1'b1;
        stop_btn = 1'b1;
        tick(12);
        check("start_stop_no_s", 2'(s_cnt), 2'd0);
        start_btn = 1'b0;
        stop_btn = 1'b0;
        tick(8);
        timer_done = 1'b1;
        tick(3);
        start_btn = 1'b1;
        tick(12);
        check("start_timer_no_s", 2'(s_cnt), 2'd0);
        check("start_timer_off", mag_on, 1'b0);
        start_btn = 1'b0;
        tick(8);
        timer_done = 1'b0;
        tick(4);

        // Reset while on, then power-up holdoff swallows an immediate press.
        start_btn = 1'b1;
        tick(8);
        check("pre_reset_on", mag_on, 1'b1);
        start_btn = 1'b0;
        tick(8);
        do_reset();
        start_btn = 1'b1;
        s_cnt = 0;
        tick(12);
        check("post_reset_no_s", 2'(s_cnt), 2'd0);
        start_btn = 1'b0;
        tick(8);
        start_btn = 1'b1;
        tick(7);
        check("post_reset_s", S, 1'b1);
        start_btn = 1'b0;
        tick(8);

        // Randomized input activity with occasional resets.
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(0, 11) == 0) start_btn = ~start_btn;
            if ($urandom_range(0, 15) == 0) stop_btn = ~stop_btn;
            if ($urandom_range(0, 24) == 0) door_closed = ~door_closed;
            if ($urandom_range(0, 29) == 0) timer_done = ~timer_done;
            if ($urandom_range(0, 299) == 0) do_reset();
            tick(1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
